// File: rtl/exp6_unidade_controle_if.sv
// ---------------------------------------------------------------------------
// exp6_unidade_controle_if
// Bundles the controller <-> datapath signals of the memory game.
//   Status (datapath -> controller): jogar, jogada_feita, jogada_correta,
//     enderecoIgualRodada, fimC, fimL, timeout
//   Control (controller -> datapath): zeraCR, contaCR, zeraE, contaE,
//     limpaRC, registraRC, zeraLeds, registraLeds, contaT, zeraT,
//     led_selector, pronto, ganhou, perdeu, db_timeout
//   Debug: db_estado (4-bit current state for the 7-segment display)
// Modports: master = controller side, slave = datapath / stimulus side.
// ---------------------------------------------------------------------------
interface exp6_unidade_controle_if;
    // status inputs to the controller
    logic       jogar;
    logic       jogada_feita;
    logic       jogada_correta;
    logic       enderecoIgualRodada;
    logic       fimC;
    logic       fimL;
    logic       timeout;
    // control outputs from the controller
    logic       zeraCR;
    logic       contaCR;
    logic       zeraE;
    logic       contaE;
    logic       limpaRC;
    logic       registraRC;
    logic       zeraLeds;
    logic       registraLeds;
    logic       contaT;
    logic       zeraT;
    logic       led_selector;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       db_timeout;
    logic [3:0] db_estado;

    modport master (
        input  jogar, jogada_feita, jogada_correta, enderecoIgualRodada,
               fimC, fimL, timeout,
        output zeraCR, contaCR, zeraE, contaE, limpaRC, registraRC,
               zeraLeds, registraLeds, contaT, zeraT, led_selector,
               pronto, ganhou, perdeu, db_timeout, db_estado
    );

    modport slave (
        output jogar, jogada_feita, jogada_correta, enderecoIgualRodada,
               fimC, fimL, timeout,
        input  zeraCR, contaCR, zeraE, contaE, limpaRC, registraRC,
               zeraLeds, registraLeds, contaT, zeraT, led_selector,
               pronto, ganhou, perdeu, db_timeout, db_estado
    );
endinterface

// File: rtl/exp6_unidade_controle.sv
// ---------------------------------------------------------------------------
// exp6_unidade_controle
// Moore control unit of the memory ("genius") game: shows the LED sequence
// of the current round, then checks the player's plays one by one.
// Ports:
//   clock  - rising-edge system clock (50 MHz)
//   reset  - asynchronous active-low reset, forces INICIAL
//   bus    - exp6_unidade_controle_if.master (status in, controls out,
//            db_estado debug state)
// Build option: define TIMEOUT_EN to enable the play-wait timeout
// (ESPERA_JOGADA -> FIM_TIMEOUT and contaT running while waiting).
// Outputs are registered and decoded from the next state, so they always
// match the state register exactly (pure Moore behaviour, glitch free).
// ---------------------------------------------------------------------------
module exp6_unidade_controle (
    input  logic                          clock,
    input  logic                          reset,
    exp6_unidade_controle_if.master       bus
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        INICIO_RODADA  = 4'h2,
        CARREGA_LED    = 4'h3,
        MOSTRA_LED     = 4'h4,
        APAGA_LED      = 4'h5,
        PROXIMO_LED    = 4'h6,
        INICIA_JOGO    = 4'h7,
        ESPERA_JOGADA  = 4'h8,
        REGISTRA       = 4'h9,
        COMPARA        = 4'hA,
        PROXIMA_JOGADA = 4'hB,
        PROXIMA_RODADA = 4'hC,
        FIM_ACERTO     = 4'hD,
        FIM_ERRO       = 4'hE,
        FIM_TIMEOUT    = 4'hF
    } state_t;

    typedef struct packed {
        logic zera_cr;
        logic conta_cr;
        logic zera_e;
        logic conta_e;
        logic limpa_rc;
        logic registra_rc;
        logic zera_leds;
        logic registra_leds;
        logic conta_t;
        logic zera_t;
        logic led_selector;
        logic pronto;
        logic ganhou;
        logic perdeu;
        logic db_timeout;
    } ctrl_t;

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl_reg;

    // Output decode for a given state; used on the next state so the
    // registered outputs line up with the registered state.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            PREPARA: begin
                c.zera_cr   = 1'b1;
                c.zera_e    = 1'b1;
                c.limpa_rc  = 1'b1;
                c.zera_leds = 1'b1;
                c.zera_t    = 1'b1;
            end
            INICIO_RODADA: begin
                c.zera_e    = 1'b1;
                c.zera_leds = 1'b1;
            end
            CARREGA_LED: begin
                c.registra_leds = 1'b1;
                c.zera_t        = 1'b1;
            end
            MOSTRA_LED: begin
                c.led_selector = 1'b1;
                c.conta_t      = 1'b1;
            end
            APAGA_LED:   c.zera_leds = 1'b1;
            PROXIMO_LED: c.conta_e   = 1'b1;
            INICIA_JOGO: begin
                c.zera_e = 1'b1;
                c.zera_t = 1'b1;
            end
            ESPERA_JOGADA: begin
`ifdef TIMEOUT_EN
                c.conta_t = 1'b1;
`else
                c.conta_t = 1'b0;
`endif
            end
            REGISTRA: c.registra_rc = 1'b1;
            PROXIMA_JOGADA: begin
                c.conta_e = 1'b1;
                c.zera_t  = 1'b1;
            end
            PROXIMA_RODADA: c.conta_cr = 1'b1;
            FIM_ACERTO: begin
                c.pronto = 1'b1;
                c.ganhou = 1'b1;
            end
            FIM_ERRO: begin
                c.pronto = 1'b1;
                c.perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                c.pronto = 1'b1;
                c.perdeu = 1'b1;
`ifdef TIMEOUT_EN
                c.db_timeout = 1'b1;
`endif
            end
            default: c = '0;
        endcase
        return c;
    endfunction

`ifndef TIMEOUT_EN
    // timeout has no effect when the feature is compiled out
    logic unused_timeout;
    assign unused_timeout = bus.timeout;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INICIAL:        if (bus.jogar) state_next = PREPARA;
            PREPARA:        state_next = INICIO_RODADA;
            INICIO_RODADA:  state_next = CARREGA_LED;
            CARREGA_LED:    state_next = MOSTRA_LED;
            MOSTRA_LED:     if (bus.fimL) state_next = APAGA_LED;
            APAGA_LED:      state_next = bus.enderecoIgualRodada ? INICIA_JOGO
                                                                 : PROXIMO_LED;
            PROXIMO_LED:    state_next = CARREGA_LED;
            INICIA_JOGO:    state_next = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // a completed play wins over a simultaneous timeout
                if (bus.jogada_feita)
                    state_next = REGISTRA;
`ifdef TIMEOUT_EN
                else if (bus.timeout)
                    state_next = FIM_TIMEOUT;
`endif
            end
            REGISTRA:       state_next = COMPARA;
            COMPARA: begin
                if (!bus.jogada_correta)
                    state_next = FIM_ERRO;
                else if (!bus.enderecoIgualRodada)
                    state_next = PROXIMA_JOGADA;
                else if (bus.fimC)
                    state_next = FIM_ACERTO;
                else
                    state_next = PROXIMA_RODADA;
            end
            PROXIMA_JOGADA: state_next = ESPERA_JOGADA;
            PROXIMA_RODADA: state_next = INICIO_RODADA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                            if (bus.jogar) state_next = PREPARA;
            default:        state_next = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= INICIAL;
            ctrl_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= decode(state_next);
        end
    end

    assign bus.zeraCR       = ctrl_reg.zera_cr;
    assign bus.contaCR      = ctrl_reg.conta_cr;
    assign bus.zeraE        = ctrl_reg.zera_e;
    assign bus.contaE       = ctrl_reg.conta_e;
    assign bus.limpaRC      = ctrl_reg.limpa_rc;
    assign bus.registraRC   = ctrl_reg.registra_rc;
    assign bus.zeraLeds     = ctrl_reg.zera_leds;
    assign bus.registraLeds = ctrl_reg.registra_leds;
    assign bus.contaT       = ctrl_reg.conta_t;
    assign bus.zeraT        = ctrl_reg.zera_t;
    assign bus.led_selector = ctrl_reg.led_selector;
    assign bus.pronto       = ctrl_reg.pronto;
    assign bus.ganhou       = ctrl_reg.ganhou;
    assign bus.perdeu       = ctrl_reg.perdeu;
    assign bus.db_timeout   = ctrl_reg.db_timeout;
    assign bus.db_estado    = state_reg;

endmodule

// File: tb/tb_exp6_unidade_controle.sv
// ---------------------------------------------------------------------------
// tb_exp6_unidade_controle
// Directed, table-driven bench for exp6_unidade_controle. Each table row is
// one clock: inputs applied, then expected state and outputs checked 1 ns
// after the rising edge. Hand-written sequences cover async reset and the
// timeout / play-priority corner cases (timeout path only with TIMEOUT_EN).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_exp6_unidade_controle;

    logic clock;
    logic reset;

    exp6_unidade_controle_if bus ();

    exp6_unidade_controle dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // input bit order: {jogar, jogada_feita, jogada_correta,
    //                   enderecoIgualRodada, fimC, fimL, timeout}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_JOG  = 7'b1000000;
    localparam logic [6:0] I_JF   = 7'b0100000;
    localparam logic [6:0] I_JC   = 7'b0010000;
    localparam logic [6:0] I_EIR  = 7'b0001000;
    localparam logic [6:0] I_FC   = 7'b0000100;
    localparam logic [6:0] I_FL   = 7'b0000010;
    localparam logic [6:0] I_TO   = 7'b0000001;

    // output bit order: {zeraCR, contaCR, zeraE, contaE, limpaRC, registraRC,
    //   zeraLeds, registraLeds, contaT, zeraT, led_selector, pronto,
    //   ganhou, perdeu, db_timeout}
    localparam logic [14:0] O_NONE = 15'h0000;
    localparam logic [14:0] O_ZCR  = 15'b100000000000000;
    localparam logic [14:0] O_CCR  = 15'b010000000000000;
    localparam logic [14:0] O_ZE   = 15'b001000000000000;
    localparam logic [14:0] O_CE   = 15'b000100000000000;
    localparam logic [14:0] O_LRC  = 15'b000010000000000;
    localparam logic [14:0] O_RRC  = 15'b000001000000000;
    localparam logic [14:0] O_ZL   = 15'b000000100000000;
    localparam logic [14:0] O_RL   = 15'b000000010000000;
    localparam logic [14:0] O_CT   = 15'b000000001000000;
    localparam logic [14:0] O_ZT   = 15'b000000000100000;
    localparam logic [14:0] O_LS   = 15'b000000000010000;
    localparam logic [14:0] O_PR   = 15'b000000000001000;
    localparam logic [14:0] O_GA   = 15'b000000000000100;
    localparam logic [14:0] O_PE   = 15'b000000000000010;
    localparam logic [14:0] O_DT   = 15'b000000000000001;

`ifdef TIMEOUT_EN
    localparam logic [14:0] O_WAIT = O_CT;
`else
    localparam logic [14:0] O_WAIT = O_NONE;
`endif

    localparam logic [14:0] O_PREP = O_ZCR | O_ZE | O_LRC | O_ZL | O_ZT;

    typedef struct {
        logic [6:0]  in;
        logic [3:0]  st;
        logic [14:0] out;
    } vec_t;

    int n_cmp;
    int n_err;

    function automatic logic [14:0] actual_outs();
        return {bus.zeraCR, bus.contaCR, bus.zeraE, bus.contaE, bus.limpaRC,
                bus.registraRC, bus.zeraLeds, bus.registraLeds, bus.contaT,
                bus.zeraT, bus.led_selector, bus.pronto, bus.ganhou,
                bus.perdeu, bus.db_timeout};
    endfunction

    task automatic drive(input logic [6:0] in);
        {bus.jogar, bus.jogada_feita, bus.jogada_correta,
         bus.enderecoIgualRodada, bus.fimC, bus.fimL, bus.timeout} = in;
    endtask

    task automatic check(input string name, input logic [3:0] st,
                         input logic [14:0] out);
        n_cmp++;
        if (bus.db_estado !== st) begin
            n_err++;
            $display("FAIL %s state: got %h expected %h", name, bus.db_estado, st);
        end
        n_cmp++;
        if (actual_outs() !== out) begin
            n_err++;
            $display("FAIL %s outputs: got %b expected %b", name, actual_outs(), out);
        end
        $display("txn %-12s state=%h outs=%b", name, bus.db_estado, actual_outs());
    endtask

    task automatic step(input string name, input logic [6:0] in,
                        input logic [3:0] st, input logic [14:0] out);
        drive(in);
        @(posedge clock);
        #1;
        check(name, st, out);
    endtask

    // from INICIAL (out of reset) to ESPERA_JOGADA in 7 clocks
    task automatic go_to_wait(input string name);
        step({name, "_p"}, I_JOG,  4'h1, O_PREP);
        step({name, "_r"}, I_NONE, 4'h2, O_ZE | O_ZL);
        step({name, "_c"}, I_NONE, 4'h3, O_RL | O_ZT);
        step({name, "_m"}, I_NONE, 4'h4, O_LS | O_CT);
        step({name, "_a"}, I_FL,   4'h5, O_ZL);
        step({name, "_i"}, I_EIR,  4'h7, O_ZE | O_ZT);
        step({name, "_w"}, I_NONE, 4'h8, O_WAIT);
    endtask

    vec_t vecs[$];

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Full game: start, 2-LED display, round 1 plays, round 2 win,
        // restart, loss by wrong play, restart.
        vecs = '{
            '{I_NONE,                    4'h0, O_NONE},
            '{I_JOG,                     4'h1, O_PREP},
            '{I_JOG,                     4'h2, O_ZE | O_ZL},
            '{I_JOG,                     4'h3, O_RL | O_ZT},
            '{I_NONE,                    4'h4, O_LS | O_CT},
            '{I_NONE,                    4'h4, O_LS | O_CT},
            '{I_NONE,                    4'h4, O_LS | O_CT},
            '{I_FL,                      4'h5, O_ZL},
            '{I_NONE,                    4'h6, O_CE},
            '{I_NONE,                    4'h3, O_RL | O_ZT},
            '{I_FL,                      4'h4, O_LS | O_CT},
            '{I_FL,                      4'h5, O_ZL},
            '{I_EIR,                     4'h7, O_ZE | O_ZT},
            '{I_JOG,                     4'h8, O_WAIT},
            '{I_JOG,                     4'h8, O_WAIT},
            '{I_JF,                      4'h9, O_RRC},
            '{I_NONE,                    4'hA, O_NONE},
            '{I_JC,                      4'hB, O_CE | O_ZT},
            '{I_NONE,                    4'h8, O_WAIT},
            '{I_JF,                      4'h9, O_RRC},
            '{I_NONE,                    4'hA, O_NONE},
            '{I_JC | I_EIR,              4'hC, O_CCR},
            '{I_NONE,                    4'h2, O_ZE | O_ZL},
            '{I_NONE,                    4'h3, O_RL | O_ZT},
            '{I_FL,                      4'h4, O_LS | O_CT},
            '{I_FL,                      4'h5, O_ZL},
            '{I_EIR,                     4'h7, O_ZE | O_ZT},
            '{I_NONE,                    4'h8, O_WAIT},
            '{I_JF,                      4'h9, O_RRC},
            '{I_NONE,                    4'hA, O_NONE},
            '{I_JC | I_EIR | I_FC,       4'hD, O_PR | O_GA},
            '{I_NONE,                    4'hD, O_PR | O_GA},
            '{I_JOG,                     4'h1, O_PREP},
            '{I_NONE,                    4'h2, O_ZE | O_ZL},
            '{I_NONE,                    4'h3, O_RL | O_ZT},
            '{I_FL,                      4'h4, O_LS | O_CT},
            '{I_FL,                      4'h5, O_ZL},
            '{I_EIR,                     4'h7, O_ZE | O_ZT},
            '{I_NONE,                    4'h8, O_WAIT},
            '{I_JF,                      4'h9, O_RRC},
            '{I_NONE,                    4'hA, O_NONE},
            '{I_EIR | I_FC,              4'hE, O_PR | O_PE},
            '{I_NONE,                    4'hE, O_PR | O_PE},
            '{I_JOG,                     4'h1, O_PREP}
        };

        // reset held for one cycle: state 0, outputs 0 without any edge
        drive(I_NONE);
        reset = 1'b0;
        #5;
        check("rst_async", 4'h0, O_NONE);
        @(posedge clock);
        #1;
        check("rst_hold", 4'h0, O_NONE);
        #4;
        reset = 1'b1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].in, vecs[i].st, vecs[i].out);
        end

        // asynchronous reset in the middle of a play
        reset = 1'b0;
        #4;
        reset = 1'b1;
        #2;
        drive(I_NONE);
        @(posedge clock);
        #1;
        check("rst_clear", 4'h0, O_NONE);
        go_to_wait("mid");
        #5;
        reset = 1'b0;
        #1;
        check("rst_mid", 4'h0, O_NONE);
        step("rst_stay", I_JOG, 4'h0, O_NONE);
        #3;
        reset = 1'b1;
        step("rst_idle", I_NONE, 4'h0, O_NONE);

        // play and timeout in the same cycle: the play wins
        go_to_wait("pri");
        step("pri_both", I_JF | I_TO, 4'h9, O_RRC);
        step("pri_cmp",  I_TO,        4'hA, O_NONE);
        step("pri_err",  I_TO,        4'hE, O_PR | O_PE);
        step("pri_rst",  I_JOG,       4'h1, O_PREP);

        // timeout alone while waiting
        step("to_r", I_NONE, 4'h2, O_ZE | O_ZL);
        step("to_c", I_NONE, 4'h3, O_RL | O_ZT);
        step("to_m", I_NONE, 4'h4, O_LS | O_CT);
        step("to_a", I_FL,   4'h5, O_ZL);
        step("to_i", I_EIR,  4'h7, O_ZE | O_ZT);
        step("to_w", I_NONE, 4'h8, O_WAIT);
`ifdef TIMEOUT_EN
        step("to_fire", I_TO,   4'hF, O_PR | O_PE | O_DT);
        step("to_hold", I_NONE, 4'hF, O_PR | O_PE | O_DT);
        step("to_rst",  I_JOG,  4'h1, O_PREP);
`else
        step("to_ign",  I_TO, 4'h8, O_WAIT);
        step("to_ign2", I_TO, 4'h8, O_WAIT);
        step("to_play", I_JF, 4'h9, O_RRC);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // absolute time bound so the bench can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
